// File: rtl/control_unit_pkg.sv
// Shared constants, types and the microcode ROM for the MSP430 control unit.
package control_unit_pkg;

  localparam int unsigned CU_CAR_BITS = 6;
  localparam int unsigned CU_CW_BITS  = 12;
  localparam int unsigned CU_ROM_BITS = CU_CW_BITS + 1;

  // Format I (two-operand) opcodes, IW[15:12]
  typedef enum logic [3:0] {
    MOV  = 4'h4, ADD = 4'h5, ADDC = 4'h6, SUBC = 4'h7,
    SUB  = 4'h8, CMP = 4'h9, DADD = 4'hA, BIT  = 4'hB,
    BIC  = 4'hC, BIS = 4'hD, XOR  = 4'hE, AND  = 4'hF
  } fmt1_op_e;

  // Format II (single-operand) opcodes, IW[9:7]
  typedef enum logic [2:0] {
    RRC = 3'd0, SWPB = 3'd1, RRA = 3'd2, SXT = 3'd3,
    PUSH = 3'd4, CALL = 3'd5, RETI = 3'd6
  } fmt2_op_e;

  // Jump conditions, IW[12:10]
  typedef enum logic [2:0] {
    JNE = 3'd0, JEQ = 3'd1, JNC = 3'd2, JC  = 3'd3,
    JN  = 3'd4, JGE = 3'd5, JL  = 3'd6, JMP = 3'd7
  } jump_op_e;

  // Source addressing modes, IW[5:4]
  typedef enum logic [1:0] {
    REGISTER = 2'b00, INDEXED = 2'b01, INDIRECT = 2'b10, INDIRECT_AUTOINC = 2'b11
  } addr_mode_e;

  localparam logic [3:0] R0  = 4'd0,  R1  = 4'd1,  R2  = 4'd2,  R3  = 4'd3;
  localparam logic [3:0] R4  = 4'd4,  R5  = 4'd5,  R6  = 4'd6,  R7  = 4'd7;
  localparam logic [3:0] R8  = 4'd8,  R9  = 4'd9,  R10 = 4'd10, R11 = 4'd11;
  localparam logic [3:0] R12 = 4'd12, R13 = 4'd13, R14 = 4'd14, R15 = 4'd15;
  localparam logic [3:0] PC  = R0,    SP  = R1,    SR  = R2;

  // ControlWord bit positions
  localparam int unsigned CW_PC_INC   = 0;
  localparam int unsigned CW_IR_LOAD  = 1;
  localparam int unsigned CW_MAR_LOAD = 2;
  localparam int unsigned CW_MEM_RD   = 3;
  localparam int unsigned CW_MEM_WR   = 4;
  localparam int unsigned CW_REG_WR   = 5;
  localparam int unsigned CW_ALU_LSB  = 6;
  localparam int unsigned CW_ALU_MSB  = 9;
  localparam int unsigned CW_SRC_SEL  = 10;
  localparam int unsigned CW_SR_WR    = 11;

  // Microcode ROM: {INTACK, ControlWord}; unlisted addresses read as zero
  function automatic logic [CU_ROM_BITS-1:0] rom_lookup(input logic [CU_CAR_BITS-1:0] car);
    logic [CU_ROM_BITS-1:0] word;
    word = '0;
    case (car)
      6'd1:    word = 13'h0003;
      6'd2:    word = 13'h0105;
      6'd3:    word = 13'h0228;
      6'd4:    word = 13'h0421;
      6'd5:    word = 13'h0811;
      6'd6:    word = 13'h0A50;
      6'd7:    word = 13'h0C82;
      6'd8:    word = 13'h00C4;
      6'd9:    word = 13'h0F0F;
      6'd10:   word = 13'h0333;
      6'd32:   word = 13'h1000;
      6'd33:   word = 13'h1009;
      6'd34:   word = 13'h0806;
      6'd63:   word = 13'h0FFF;
      default: word = '0;
    endcase
    return word;
  endfunction

endpackage

// File: rtl/control_unit_if.sv
// Sequencer/datapath-facing bus of the control unit.
interface control_unit_if #(parameter int unsigned CAR_BITS = 6);
  logic [CAR_BITS-1:0] CAR;
  logic [15:0]         IR;
  logic [15:0]         IW;
  logic [3:0]          srcA;
  logic [1:0]          As;
  logic [3:0]          dstA;
  logic                Ad;
  logic                Format;
  logic                INTACK;
  logic [11:0]         ControlWord;

  modport master (
    output CAR, IR,
    input  IW, srcA, As, dstA, Ad, Format, INTACK, ControlWord
  );

  modport slave (
    input  CAR, IR,
    output IW, srcA, As, dstA, Ad, Format, INTACK, ControlWord
  );
endinterface

// File: rtl/control_unit_decoder.sv
// Combinational instruction decode: IW -> register addresses and addressing modes.
module cu_decoder
  import control_unit_pkg::*;
(
  input  logic [15:0] i_iw,
  output logic [3:0]  o_src_a,
  output logic [1:0]  o_as,
  output logic [3:0]  o_dst_a,
  output logic        o_ad,
  output logic        o_format
);

  // Byte/word flag has no influence on addresses or modes
  logic w_unused_bw;
  assign w_unused_bw = i_iw[6];

  // Classify the instruction and extract operand fields; invalid decodes to all zero
  always_comb begin
    o_src_a  = R0;
    o_as     = REGISTER;
    o_dst_a  = R0;
    o_ad     = 1'b0;
    o_format = 1'b0;
    if (i_iw[15:12] >= 4'd4) begin
      o_src_a  = i_iw[11:8];
      o_ad     = i_iw[7];
      o_as     = i_iw[5:4];
      o_dst_a  = i_iw[3:0];
      o_format = 1'b1;
    end else if (i_iw[15:10] == 6'b000100) begin
      case (i_iw[9:7])
        RRC, SWPB, RRA, SXT: begin
          o_src_a = i_iw[3:0];
          o_dst_a = i_iw[3:0];
          o_as    = i_iw[5:4];
        end
        PUSH, CALL: begin
          o_src_a = i_iw[3:0];
          o_dst_a = SP;
          o_as    = i_iw[5:4];
        end
        RETI: begin
          o_src_a = SP;
          o_dst_a = SP;
          o_as    = REGISTER;
        end
        default: ;
      endcase
    end else if (i_iw[15:13] == 3'b001) begin
      o_src_a = PC;
      o_dst_a = PC;
    end
  end

endmodule

// File: rtl/control_unit.sv
// MSP430 microcoded control unit: instruction latch, decode and microcode ROM lookup.
module control_unit
  import control_unit_pkg::*;
#(
  parameter int unsigned CAR_BITS  = CU_CAR_BITS,
  parameter int unsigned FETCH_CAR = 0
) (
  input  logic clk,
  input  logic rst,
  control_unit_if.slave bus
);

  logic [15:0]            r_iw;
  logic                   w_fetch;
  logic [CU_ROM_BITS-1:0] w_rom;

  assign w_fetch = (bus.CAR == CAR_BITS'(FETCH_CAR));

  // Instruction word latch, loaded only in the fetch micro-state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_iw <= 16'h0000;
    end else if (w_fetch) begin
      r_iw <= bus.IR;
    end
  end

  cu_decoder u_decoder (
    .i_iw     (r_iw),
    .o_src_a  (bus.srcA),
    .o_as     (bus.As),
    .o_dst_a  (bus.dstA),
    .o_ad     (bus.Ad),
    .o_format (bus.Format)
  );

  assign w_rom           = rom_lookup(CU_CAR_BITS'(bus.CAR));
  assign bus.IW          = r_iw;
  assign bus.INTACK      = w_rom[CU_CW_BITS];
  assign bus.ControlWord = w_rom[CU_CW_BITS-1:0];

endmodule

// File: tb/tb_control_unit.sv
// Directed self-checking bench for control_unit.
module tb_control_unit;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  control_unit_if #(.CAR_BITS(6)) bus ();

  control_unit #(.CAR_BITS(6), .FETCH_CAR(0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hand-written golden ROM image
  function automatic logic [12:0] exp_rom(input int a);
    case (a)
      1:  return 13'h0003;
      2:  return 13'h0105;
      3:  return 13'h0228;
      4:  return 13'h0421;
      5:  return 13'h0811;
      6:  return 13'h0A50;
      7:  return 13'h0C82;
      8:  return 13'h00C4;
      9:  return 13'h0F0F;
      10: return 13'h0333;
      32: return 13'h1000;
      33: return 13'h1009;
      34: return 13'h0806;
      63: return 13'h0FFF;
      default: return 13'h0000;
    endcase
  endfunction

  // Present IR in the fetch state for one rising edge, then settle
  task automatic load(input logic [15:0] ir);
    @(negedge clk);
    bus.CAR = 6'd0;
    bus.IR  = ir;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst     = 1'b1;
    bus.CAR = 6'd3;
    bus.IR  = 16'h4A0B;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (bus.IW !== 16'h0000) begin
      n_fail++; $display("FAIL reset_iw got %h want 0000", bus.IW);
    end
    n_checks++;
    if ({bus.srcA, bus.dstA, bus.As, bus.Ad, bus.Format} !== 12'h000) begin
      n_fail++;
      $display("FAIL reset_decode got src=%0d dst=%0d as=%0d ad=%0d fmt=%0d want all 0",
               bus.srcA, bus.dstA, bus.As, bus.Ad, bus.Format);
    end
    n_checks++;
    if ({bus.INTACK, bus.ControlWord} !== 13'h0228) begin
      n_fail++; $display("FAIL reset_rom got %h want 0228", {bus.INTACK, bus.ControlWord});
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_format1();
    load(16'h440A);
    n_checks++;
    if ({bus.IW, bus.srcA, bus.As, bus.dstA, bus.Ad, bus.Format} !== {16'h440A, 4'd4, 2'b00, 4'd10, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL fmt1_mov_reg got iw=%h src=%0d as=%0d dst=%0d ad=%0d fmt=%0d want 440A 4 0 10 0 1",
               bus.IW, bus.srcA, bus.As, bus.dstA, bus.Ad, bus.Format);
    end
    load(16'hF3B6);
    n_checks++;
    if ({bus.srcA, bus.As, bus.dstA, bus.Ad, bus.Format} !== {4'd3, 2'b11, 4'd6, 1'b1, 1'b1}) begin
      n_fail++;
      $display("FAIL fmt1_and got src=%0d as=%0d dst=%0d ad=%0d fmt=%0d want 3 3 6 1 1",
               bus.srcA, bus.As, bus.dstA, bus.Ad, bus.Format);
    end
    load(16'h45CB);
    n_checks++;
    if ({bus.srcA, bus.As, bus.dstA, bus.Ad, bus.Format} !== {4'd5, 2'b00, 4'd11, 1'b1, 1'b1}) begin
      n_fail++;
      $display("FAIL fmt1_movb_idx got src=%0d as=%0d dst=%0d ad=%0d fmt=%0d want 5 0 11 1 1",
               bus.srcA, bus.As, bus.dstA, bus.Ad, bus.Format);
    end
  endtask

  task automatic test_hold();
    @(negedge clk);
    bus.CAR = 6'd5;
    bus.IR  = 16'h1234;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (bus.IW !== 16'h45CB) begin
      n_fail++; $display("FAIL hold_iw got %h want 45CB", bus.IW);
    end
  endtask

  task automatic test_format2();
    load(16'h1129);
    n_checks++;
    if ({bus.srcA, bus.dstA, bus.As, bus.Ad, bus.Format} !== {4'd9, 4'd9, 2'b10, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL fmt2_rra got src=%0d dst=%0d as=%0d ad=%0d fmt=%0d want 9 9 2 0 0",
               bus.srcA, bus.dstA, bus.As, bus.Ad, bus.Format);
    end
    load(16'h11A6);
    n_checks++;
    if ({bus.srcA, bus.dstA, bus.As, bus.Format} !== {4'd6, 4'd6, 2'b10, 1'b0}) begin
      n_fail++;
      $display("FAIL fmt2_sxt got src=%0d dst=%0d as=%0d fmt=%0d want 6 6 2 0",
               bus.srcA, bus.dstA, bus.As, bus.Format);
    end
    load(16'h1217);
    n_checks++;
    if ({bus.srcA, bus.dstA, bus.As, bus.Format} !== {4'd7, 4'd1, 2'b01, 1'b0}) begin
      n_fail++;
      $display("FAIL fmt2_push got src=%0d dst=%0d as=%0d fmt=%0d want 7 1 1 0",
               bus.srcA, bus.dstA, bus.As, bus.Format);
    end
    load(16'h12B5);
    n_checks++;
    if ({bus.srcA, bus.dstA, bus.As, bus.Format} !== {4'd5, 4'd1, 2'b11, 1'b0}) begin
      n_fail++;
      $display("FAIL fmt2_call got src=%0d dst=%0d as=%0d fmt=%0d want 5 1 3 0",
               bus.srcA, bus.dstA, bus.As, bus.Format);
    end
    load(16'h1330);
    n_checks++;
    if ({bus.srcA, bus.dstA, bus.As, bus.Ad, bus.Format} !== {4'd1, 4'd1, 2'b00, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL fmt2_reti got src=%0d dst=%0d as=%0d ad=%0d fmt=%0d want 1 1 0 0 0",
               bus.srcA, bus.dstA, bus.As, bus.Ad, bus.Format);
    end
  endtask

  task automatic test_jump_invalid();
    load(16'h3C00);
    n_checks++;
    if ({bus.srcA, bus.dstA, bus.As, bus.Ad, bus.Format} !== 12'h000) begin
      n_fail++;
      $display("FAIL jump_jmp got src=%0d dst=%0d as=%0d ad=%0d fmt=%0d want all 0",
               bus.srcA, bus.dstA, bus.As, bus.Ad, bus.Format);
    end
    // Format II opcode 7 is invalid even though As/register bits are set
    load(16'h13B5);
    n_checks++;
    if ({bus.srcA, bus.dstA, bus.As, bus.Ad, bus.Format} !== 12'h000) begin
      n_fail++;
      $display("FAIL fmt2_op7 got src=%0d dst=%0d as=%0d ad=%0d fmt=%0d want all 0",
               bus.srcA, bus.dstA, bus.As, bus.Ad, bus.Format);
    end
    load(16'h14B5);
    n_checks++;
    if ({bus.srcA, bus.dstA, bus.As, bus.Ad, bus.Format} !== 12'h000) begin
      n_fail++;
      $display("FAIL invalid_14xx got src=%0d dst=%0d as=%0d ad=%0d fmt=%0d want all 0",
               bus.srcA, bus.dstA, bus.As, bus.Ad, bus.Format);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] seq [3];
    seq[0] = 16'h5A3C;
    seq[1] = 16'h2001;
    seq[2] = 16'h8E97;
    @(negedge clk);
    bus.CAR = 6'd0;
    for (int i = 0; i < 3; i++) begin
      bus.IR = seq[i];
      @(posedge clk);
      #1;
      n_checks++;
      if (bus.IW !== seq[i]) begin
        n_fail++; $display("FAIL b2b_iw[%0d] got %h want %h", i, bus.IW, seq[i]);
      end
    end
    // Last word 8E97: SUB, src=14, Ad=1, As=01, dst=7
    n_checks++;
    if ({bus.srcA, bus.As, bus.dstA, bus.Ad, bus.Format} !== {4'd14, 2'b01, 4'd7, 1'b1, 1'b1}) begin
      n_fail++;
      $display("FAIL b2b_decode got src=%0d as=%0d dst=%0d ad=%0d fmt=%0d want 14 1 7 1 1",
               bus.srcA, bus.As, bus.dstA, bus.Ad, bus.Format);
    end
  endtask

  task automatic test_reset_midop();
    load(16'hF3B6);
    @(negedge clk);
    bus.CAR = 6'd9;
    #1;
    rst = 1'b1;
    #1;
    n_checks++;
    if (bus.IW !== 16'h0000) begin
      n_fail++; $display("FAIL midop_async_iw got %h want 0000", bus.IW);
    end
    n_checks++;
    if ({bus.srcA, bus.dstA, bus.As, bus.Ad, bus.Format} !== 12'h000) begin
      n_fail++;
      $display("FAIL midop_decode got src=%0d dst=%0d as=%0d ad=%0d fmt=%0d want all 0",
               bus.srcA, bus.dstA, bus.As, bus.Ad, bus.Format);
    end
    n_checks++;
    if ({bus.INTACK, bus.ControlWord} !== 13'h0F0F) begin
      n_fail++; $display("FAIL midop_rom got %h want 0F0F", {bus.INTACK, bus.ControlWord});
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_rom_sweep();
    for (int a = 0; a < 64; a++) begin
      @(negedge clk);
      bus.CAR = 6'(a);
      #1;
      n_checks++;
      if ({bus.INTACK, bus.ControlWord} !== exp_rom(a)) begin
        n_fail++;
        $display("FAIL rom[%0d] got %h want %h", a, {bus.INTACK, bus.ControlWord}, exp_rom(a));
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    bus.CAR  = 6'd0;
    bus.IR   = 16'h0000;
    test_reset();
    test_format1();
    test_hold();
    test_format2();
    test_jump_invalid();
    test_back_to_back();
    test_reset_midop();
    test_rom_sweep();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

endmodule
